// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// register offsets within the sysid slave, and the timeout counter width.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [31:0] ID_OFFSET = 32'd0;
  localparam logic [31:0] TS_OFFSET = 32'd4;
  localparam int          TMO_WIDTH = 16;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Counts waitrequest stall cycles of one Avalon read and flags the stall
// cycle that brings the count to TIMEOUT_CYCLES.
module sysid_timeout_ctr
  import sysid_checker_pkg::*;
#(
  parameter logic [TMO_WIDTH-1:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TMO_WIDTH-1:0] LAST = TIMEOUT_CYCLES - 16'd1;

  logic [TMO_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // tc is raised in the stall cycle whose edge would take count to TIMEOUT_CYCLES,
  // so the read strobe is held for exactly TIMEOUT_CYCLES stalled cycles.
  assign tc = enable && (count == LAST);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// checks them against build-time expected values.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0]          EXPECTED_ID        = 32'd0,
  parameter logic [31:0]          EXPECTED_TIMESTAMP = 32'd1383139318,
  parameter logic [TMO_WIDTH-1:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  state_t state, state_next;
  logic   in_rd;
  logic   tc;
  logic   id_mis_next, ts_mis_next, tmo_next;

  assign in_rd = (state == RD_ID) || (state == RD_TS);

  sysid_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!in_rd || !avm_waitrequest),
    .enable  (in_rd && avm_waitrequest),
    .tc      (tc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    id_mis_next = id_mismatch;
    ts_mis_next = ts_mismatch;
    tmo_next    = timeout;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RD_ID;
          id_mis_next = 1'b0;
          ts_mis_next = 1'b0;
          tmo_next    = 1'b0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          state_next  = RD_TS;
          id_mis_next = (avm_readdata != EXPECTED_ID);
        end else if (tc) begin
          state_next = FINISH;
          tmo_next   = 1'b1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          state_next  = FINISH;
          ts_mis_next = (avm_readdata != EXPECTED_TIMESTAMP);
        end else if (tc) begin
          state_next = FINISH;
          tmo_next   = 1'b1;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Verdict is latched on the edge into FINISH so it already reflects a flag set on that edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
    end else begin
      id_mismatch <= id_mis_next;
      ts_mismatch <= ts_mis_next;
      timeout     <= tmo_next;
      if (state == IDLE && start) begin
        pass <= 1'b0;
      end else if (in_rd && state_next == FINISH) begin
        pass <= !id_mis_next && !ts_mis_next && !tmo_next;
      end
      if (state == RD_ID && !avm_waitrequest) begin
        captured_id <= avm_readdata;
      end
      if (state == RD_TS && !avm_waitrequest) begin
        captured_ts <= avm_readdata;
      end
    end
  end

  always_comb begin
    avm_read    = in_rd;
    avm_address = BASE_ADDR + ((state == RD_TS) ? TS_OFFSET : ID_OFFSET);
    busy        = (state != IDLE);
    done        = (state == FINISH);
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed self-checking bench for sysid_checker with a small behavioural
// sysid slave whose data and stall pattern are scripted step by step.
module tb_sysid_checker;

  localparam logic [31:0] BASE   = 32'h0001_0000;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1383139318;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] captured_id, captured_ts;
  logic [31:0] id_val, ts_val;

  int total = 0;
  int bad   = 0;

  sysid_checker #(
    .BASE_ADDR          (BASE),
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .TIMEOUT_CYCLES     (16'd4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_mismatch     (id_mismatch),
    .ts_mismatch     (ts_mismatch),
    .timeout         (timeout),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave drives garbage while stalling so any premature sampling shows up.
  always_comb begin
    if (avm_waitrequest)
      avm_readdata = 32'hDEAD_BEEF;
    else if (avm_address == BASE)
      avm_readdata = id_val;
    else if (avm_address == BASE + 32'd4)
      avm_readdata = ts_val;
    else
      avm_readdata = 32'h0BAD_0BAD;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    avm_waitrequest = 1'b0;
    id_val = EXP_ID;
    ts_val = EXP_TS;
    tick();
    tick();
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_flags", {26'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    chk("rst_cap_id", captured_id, 32'd0);
    chk("rst_cap_ts", captured_ts, 32'd0);
    reset_n = 1'b1;
    tick();

    // Zero-wait sequence: reads in cycles 1 and 2, done and pass in cycle 3.
    start = 1'b1;
    chk("t1_c0_busy", {31'd0, busy}, 32'd0);
    tick(); start = 1'b0;
    chk("t1_c1_read", {31'd0, avm_read}, 32'd1);
    chk("t1_c1_addr", avm_address, BASE);
    chk("t1_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_c2_read", {31'd0, avm_read}, 32'd1);
    chk("t1_c2_addr", avm_address, BASE + 32'd4);
    tick();
    chk("t1_c3_done_pass_read", {29'd0, done, pass, avm_read}, 32'b110);
    chk("t1_c3_flags", {29'd0, id_mismatch, ts_mismatch, timeout}, 32'd0);
    chk("t1_cap_id", captured_id, EXP_ID);
    chk("t1_cap_ts", captured_ts, EXP_TS);
    tick();
    chk("t1_c4_done_busy", {30'd0, done, busy}, 32'd0);

    // Timestamp off by one.
    ts_val = EXP_TS + 32'd1;
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_flags_pass", {28'd0, pass, id_mismatch, ts_mismatch, timeout}, 32'b0010);
    chk("t2_cap_ts", captured_ts, EXP_TS + 32'd1);
    tick();

    // Three stall cycles per read; done lands in cycle 9.
    ts_val = EXP_TS;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      avm_waitrequest = (c != 4) && (c != 8);
      if (c == 1) chk("t3_cleared", {31'd0, ts_mismatch}, 32'd0);
      chk($sformatf("t3_c%0d_read", c), {31'd0, avm_read}, 32'd1);
      chk($sformatf("t3_c%0d_addr", c), avm_address, (c <= 4) ? BASE : BASE + 32'd4);
      chk($sformatf("t3_c%0d_done", c), {31'd0, done}, 32'd0);
    end
    tick();
    avm_waitrequest = 1'b0;
    chk("t3_c9_done_pass", {30'd0, done, pass}, 32'b11);
    chk("t3_cap_id", captured_id, EXP_ID);
    chk("t3_cap_ts", captured_ts, EXP_TS);
    tick();

    // ID read stuck: abort after four stall cycles, captured_id untouched.
    id_val = 32'h0000_1234;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      avm_waitrequest = 1'b1;
      chk($sformatf("t4_c%0d_read", c), {31'd0, avm_read}, 32'd1);
      chk($sformatf("t4_c%0d_addr", c), avm_address, BASE);
    end
    tick();
    chk("t4_c5_read", {31'd0, avm_read}, 32'd0);
    chk("t4_c5_done_pass_tmo", {29'd0, done, pass, timeout}, 32'b101);
    chk("t4_cap_id", captured_id, EXP_ID);
    tick();
    chk("t4_c6_read_busy", {30'd0, avm_read, busy}, 32'd0);
    avm_waitrequest = 1'b0;

    // Reset asserted while the timestamp read is stalled.
    id_val = 32'd1;
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); avm_waitrequest = 1'b1;
    chk("t5_c2_idmis", {31'd0, id_mismatch}, 32'd1);
    chk("t5_c2_read", {31'd0, avm_read}, 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_read", {31'd0, avm_read}, 32'd0);
    chk("t5_async_flags", {26'd0, busy, done, pass, id_mismatch, ts_mismatch, timeout}, 32'd0);
    chk("t5_async_cap_id", captured_id, 32'd0);
    tick();
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    id_val = EXP_ID;
    chk("t5_post_done", {30'd0, done, busy}, 32'd0);
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    tick();
    chk("t5_rerun_done_pass", {30'd0, done, pass}, 32'b11);
    tick();

    // start held through the whole sequence is not queued.
    ts_val = EXP_TS + 32'd7;
    start = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_c3_done", {31'd0, done}, 32'd1);
    tick(); start = 1'b0;
    chk("t6_c4_idle", {30'd0, avm_read, busy}, 32'd0);
    chk("t6_c4_tsmis", {31'd0, ts_mismatch}, 32'd1);
    tick();
    chk("t6_c5_idle", {30'd0, avm_read, busy}, 32'd0);
    ts_val = EXP_TS;
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t6_rerun_cleared", {31'd0, ts_mismatch}, 32'd0);
    tick();
    tick();
    chk("t6_rerun_done_pass", {30'd0, done, pass}, 32'b11);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
